ecc_point_checker: RTL
======================

Name: ecc_point_checker

Overview:
Consumer-side block for the scalar-multiplication result (x3, y3, done). It captures an affine point and checks y^2 == x^3 + a*x + b (mod p) using a bit-serial interleaved modular multiplier. It reports a one-cycle valid pulse with an on_curve verdict, and is used after double_and_add to self-check kP in hardware.

Parameters:
n, 10, operand width in bits; requires 3 <= p < 2^(n-1) so that 2*acc and acc+operand fit in n bits.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-low reset (reset==0 resets the block).
start  input  1  capture request; connect to the producer's done.
p  input  n  odd prime modulus.
a  input  n  curve coefficient of x; must be < p (not checked).
b  input  n  curve constant; must be < p (not checked).
x  input  n  point x coordinate.
y  input  n  point y coordinate.
busy  output  1  high from the cycle after start is accepted until valid deasserts.
valid  output  1  one-cycle result strobe.
on_curve  output  1  verdict; meaningful while valid==1, held until the next accept.

Behaviour:
- Reset (async, reset==0): state=IDLE; busy=0, valid=0, on_curve=0; accumulator and captured operands cleared.
- IDLE: if start==1 at a rising edge, capture p, a, b, x, y, go to MUL_YY, busy=1. start is level-sampled; if start is still high when the FSM returns to IDLE, a new check begins.
- Start while busy: ignored. Input changes after capture: ignored.
- Range flag: set at capture if x>=p or y>=p. The full sequence still runs, but on_curve is forced to 0.
- Modular multiply, n cycles, MSB-first over multiplier bit i = n-1..0:
  - acc <= (2*acc mod p); then, if bit i is set, acc <= (acc + multiplicand) mod p.
  - Each reduction is a single conditional subtract of p.
  - acc is cleared at the start of each multiply.
- MUL_YY (n cycles): L = y*y mod p.
- MUL_XX (n cycles): T = x*x mod p.
- MUL_XXX (n cycles): T = T*x mod p.
- MUL_AX (n cycles): R = a*x mod p.
- CMP (1 cycle):
  - S = (T + R) mod p, then S = (S + b) mod p, each with a conditional subtract.
  - on_curve <= (L == S) && !range_flag.
- DONE (1 cycle): valid=1, then IDLE. busy drops together with valid.
- Latency: valid is high exactly in the cycle after the (4n+1)-th rising edge following the accepting edge, i.e. valid is first seen at edge 4n+2. For n=10 that is edge 42.
- Back-to-back: the earliest next accept is the edge that ends DONE. The total period is 4n+2 cycles.
- Reset mid-operation: immediate return to IDLE with all outputs 0; no valid is produced.
- p is taken from the captured copy only. Behaviour for even or out-of-range p is undefined.

Optional Feature:
ECC_CHECKER_DEBUG_EN:
- Defined: adds outputs lhs[n-1:0] (=L) and rhs[n-1:0] (=S). Both are registered in CMP, reset to 0, and held with on_curve.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- p=17, a=2, b=2, (x,y)=(5,1), start pulse -> valid at edge 42, on_curve=1; with debug: lhs=1, rhs=1.
- Same curve, (3,1) (the 4P result from double_and_add with k=4) -> on_curve=1. Also (0,6) -> on_curve=1 (lhs=rhs=2).
- (5,2) -> on_curve=0; debug lhs=4, rhs=1.
- (17,1), i.e. x==p -> valid at edge 42, on_curve=0.
- Accept (5,1), toggle start and x every cycle while busy -> a single valid, on_curve=1. Hold start high -> valid pulses every 42 cycles.
- Accept (5,1), assert reset low at edge 20 -> busy=valid=on_curve=0 immediately and no valid follows. After release, (3,1) checks correctly.

Source files
------------

// File: rtl/ecc_point_checker.sv
// Checks y^2 == x^3 + a*x + b (mod p) on a captured affine point; optional ECC_CHECKER_DEBUG_EN exposes lhs/rhs.
// Latency: valid strobes 4n+2 cycles after the accepting edge; back-to-back period is 4n+2.
// Backpressure: none; start is ignored while busy, a held start re-accepts at the edge ending DONE.
module ecc_point_checker #(
  parameter int n = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] p,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  output logic         busy,
  output logic         valid,
  output logic         on_curve
`ifdef ECC_CHECKER_DEBUG_EN
  ,
  output logic [n-1:0] lhs,
  output logic [n-1:0] rhs
`endif
);

  localparam int CW = $clog2(n);
  localparam logic [CW-1:0] CNT_LAST = CW'(n - 1);

  typedef enum logic [2:0] {
    IDLE, MUL_YY, MUL_XX, MUL_XXX, MUL_AX, CMP, DONE
  } state_t;

  state_t state, state_nxt;

  logic [n-1:0]  p_q, a_q, b_q, x_q, y_q;
  logic          range_q;
  logic [n-1:0]  acc, l_q, t_q, r_q;
  logic [CW-1:0] cnt;

  logic          accept, last;
  logic [n-1:0]  mcand, mplier;
  logic [n-1:0]  dbl, dbl_r, add, acc_nxt;
  logic [n-1:0]  s1, s1_r, s2, s_r;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    valid     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = MUL_YY;
      end
      MUL_YY:  if (last) state_nxt = MUL_XX;
      MUL_XX:  if (last) state_nxt = MUL_XXX;
      MUL_XXX: if (last) state_nxt = MUL_AX;
      MUL_AX:  if (last) state_nxt = CMP;
      CMP:     state_nxt = DONE;
      DONE: begin
        valid     = 1'b1;
        state_nxt = start ? MUL_YY : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand routing per multiply phase; x^3 reuses T as the multiplicand.
  always_comb begin
    mcand  = '0;
    mplier = '0;
    case (state)
      MUL_YY:  begin mcand = y_q; mplier = y_q; end
      MUL_XX:  begin mcand = x_q; mplier = x_q; end
      MUL_XXX: begin mcand = t_q; mplier = x_q; end
      MUL_AX:  begin mcand = a_q; mplier = x_q; end
      default: begin mcand = '0;  mplier = '0;  end
    endcase
  end

  // One MSB-first interleaved step: double-reduce, then conditional add-reduce.
  always_comb begin
    dbl     = acc << 1;
    dbl_r   = (dbl >= p_q) ? (dbl - p_q) : dbl;
    add     = dbl_r + mcand;
    acc_nxt = dbl_r;
    if (mplier[cnt]) acc_nxt = (add >= p_q) ? (add - p_q) : add;
  end

  always_comb begin
    s1   = t_q + r_q;
    s1_r = (s1 >= p_q) ? (s1 - p_q) : s1;
    s2   = s1_r + b_q;
    s_r  = (s2 >= p_q) ? (s2 - p_q) : s2;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      range_q  <= 1'b0;
      acc      <= '0;
      l_q      <= '0;
      t_q      <= '0;
      r_q      <= '0;
      cnt      <= '0;
      on_curve <= 1'b0;
`ifdef ECC_CHECKER_DEBUG_EN
      lhs      <= '0;
      rhs      <= '0;
`endif
    end else if (accept) begin
      p_q      <= p;
      a_q      <= a;
      b_q      <= b;
      x_q      <= x;
      y_q      <= y;
      range_q  <= (x >= p) || (y >= p);
      acc      <= '0;
      cnt      <= CNT_LAST;
      on_curve <= 1'b0;
`ifdef ECC_CHECKER_DEBUG_EN
      lhs      <= '0;
      rhs      <= '0;
`endif
    end else begin
      case (state)
        MUL_YY, MUL_XX, MUL_XXX, MUL_AX: begin
          if (last) begin
            acc <= '0;
            cnt <= CNT_LAST;
            case (state)
              MUL_YY:  l_q <= acc_nxt;
              MUL_AX:  r_q <= acc_nxt;
              default: t_q <= acc_nxt;
            endcase
          end else begin
            acc <= acc_nxt;
            cnt <= cnt - CW'(1);
          end
        end
        CMP: begin
          on_curve <= (l_q == s_r) && !range_q;
`ifdef ECC_CHECKER_DEBUG_EN
          lhs      <= l_q;
          rhs      <= s_r;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
